// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter in front of a single-port synchronous RAM.
//
// Grants are combinational, so a lone requester's access executes in the same
// cycle it asks. When both masters request, the one not granted most recently
// wins. The exception is a lock: a lock from the previous owner lets it keep
// the RAM for up to MAXLOCK further consecutive grants.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   mX_req/we/lock        master X request, write (1) / read (0), keep-ownership hint
//   mX_addr/wdata         master X word address and write data
//   mX_gnt                master X granted this cycle (combinational)
//   mX_rvalid/rdata       read data for master X, one cycle after a granted read
//   ram_we/addr/din       RAM command, taken from the granted master (zero when idle)
//   ram_dout              RAM read data (registered inside the RAM)
module ram_arbiter #(
  parameter int SIZE    = 14,
  parameter int MAXLOCK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic            m0_lock,
  input  logic [SIZE-1:0] m0_addr,
  input  logic [31:0]     m0_wdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic            m1_lock,
  input  logic [SIZE-1:0] m1_addr,
  input  logic [31:0]     m1_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [31:0]     m0_rdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [31:0]     m1_rdata,
  output logic            ram_we,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_din,
  input  logic [31:0]     ram_dout
);

  localparam logic [3:0] MAXLOCK_C = 4'(MAXLOCK);

  // last_q: 1 = master 1 was granted most recently.
  // lock_q: the most recent grant went to a master that had its lock raised.
  logic       last_q, last_d;
  logic       lock_q, lock_d;
  logic [3:0] cnt_q,  cnt_d;
  logic       rv0_q,  rv0_d;
  logic       rv1_q,  rv1_d;
  logic       gnt0,   gnt1;

  // Grant decision. Holding rst low blocks every grant, and ram_we with it.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (m0_req && !m1_req) begin
        gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (lock_q && (cnt_q < MAXLOCK_C)) begin
          // The locked owner keeps the RAM.
          gnt0 = ~last_q;
          gnt1 = last_q;
        end else begin
          // Round-robin tie, or the lock budget is spent: the other master wins.
          gnt0 = last_q;
          gnt1 = ~last_q;
        end
      end
    end
  end

  always_comb begin
    last_d = last_q;
    lock_d = 1'b0;
    cnt_d  = 4'd0;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      lock_d = gnt1 ? m1_lock : m0_lock;
      // A grant counts as locked only if the same owner is granted again while
      // its lock is held. A change of owner leaves the count at its cleared default.
      if ((gnt1 == last_q) && lock_q) begin
        cnt_d = (cnt_q == MAXLOCK_C) ? cnt_q : cnt_q + 4'd1;
      end
    end
    rv0_d = gnt0 & ~m0_we;
    rv1_d = gnt1 & ~m1_we;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
      lock_q <= 1'b0;
      cnt_q  <= 4'd0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0) begin
      ram_we   = m0_we;
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
    end else if (gnt1) begin
      ram_we   = m1_we;
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scenario tasks plus a randomized run, checked each cycle
// against a behavioural arbiter/memory model. Also holds a write-first RAM with
// a registered read that feeds the DUT's ram_dout.
module tb_ram_arbiter;
  localparam int SIZE    = 14;
  localparam int MAXLOCK = 8;
  localparam int DEPTH   = 1 << SIZE;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [SIZE-1:0] m0_addr, m1_addr;
  logic [31:0]     m0_wdata, m1_wdata;
  logic            m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]     m0_rdata, m1_rdata;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_din;
  logic [31:0]     ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.SIZE(SIZE), .MAXLOCK(MAXLOCK)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM seen by the DUT: write-first, one-cycle registered read.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_din;
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [DEPTH];
  int          mdl_last;       // master granted most recently
  bit          mdl_locked;     // previous grant was made with the owner's lock up
  int          mdl_streak;     // locked re-grants to the current owner
  bit          mdl_pend_rv [2];
  logic [31:0] mdl_pend_data;
  int          exp_winner;     // -1: no grant
  logic [50:0] exp_vec, obs_vec;

  task automatic model_reset();
    mdl_last = 1;
    mdl_locked = 0;
    mdl_streak = 0;
    mdl_pend_rv[0] = 0;
    mdl_pend_rv[1] = 0;
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    ram_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Expected outputs for the current cycle, from the inputs and the model state.
  task automatic model_eval();
    logic            we;
    logic [SIZE-1:0] a;
    logic [31:0]     d;
    exp_winner = -1;
    if (rst) begin
      if (m0_req && m1_req) begin
        if (mdl_locked && mdl_streak < MAXLOCK) exp_winner = mdl_last;
        else exp_winner = 1 - mdl_last;
      end else if (m0_req) exp_winner = 0;
      else if (m1_req) exp_winner = 1;
    end
    we = 0; a = '0; d = '0;
    if (exp_winner == 0) begin we = m0_we; a = m0_addr; d = m0_wdata; end
    if (exp_winner == 1) begin we = m1_we; a = m1_addr; d = m1_wdata; end
    exp_vec = {exp_winner == 0, exp_winner == 1, we, a, d,
               rst & mdl_pend_rv[0], rst & mdl_pend_rv[1]};
    obs_vec = {m0_gnt, m1_gnt, ram_we, ram_addr, ram_din, m0_rvalid, m1_rvalid};
  endtask

  // State update at the clock edge; exp_winner still holds this cycle's grant.
  task automatic model_commit();
    logic            lk, wr;
    logic [SIZE-1:0] a;
    logic [31:0]     d;
    if (!rst) begin
      model_reset();
    end else if (exp_winner < 0) begin
      mdl_locked = 0;
      mdl_streak = 0;
      mdl_pend_rv[0] = 0;
      mdl_pend_rv[1] = 0;
    end else begin
      lk = (exp_winner == 0) ? m0_lock  : m1_lock;
      wr = (exp_winner == 0) ? m0_we    : m1_we;
      a  = (exp_winner == 0) ? m0_addr  : m1_addr;
      d  = (exp_winner == 0) ? m0_wdata : m1_wdata;
      if (exp_winner == mdl_last && mdl_locked)
        mdl_streak = (mdl_streak < MAXLOCK) ? mdl_streak + 1 : MAXLOCK;
      else
        mdl_streak = 0;
      mdl_locked = lk;
      mdl_last = exp_winner;
      if (wr) ref_mem[a] = d;
      mdl_pend_rv[0] = (exp_winner == 0) && !wr;
      mdl_pend_rv[1] = (exp_winner == 1) && !wr;
      mdl_pend_data = ref_mem[a];
    end
  endtask

  task automatic set_m0(input logic req, input logic we, input logic lock,
                        input int a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = SIZE'(a); m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic lock,
                        input int a, input logic [31:0] d);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = SIZE'(a); m1_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    set_m0(1, 1, 1, 7, 32'h1234);
    set_m1(1, 1, 0, 9, 32'h5678);
    @(negedge clk);
    model_eval();
    n_tests++;
    if ({m0_gnt, m1_gnt, ram_we, m0_rvalid, m1_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt/we/rvalid=%b required 00000",
               {m0_gnt, m1_gnt, ram_we, m0_rvalid, m1_rvalid});
    end
    @(posedge clk); model_commit(); #1;
    rst = 1'b1;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
  endtask

  task automatic test_single_read();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) set_m0(1, 0, 0, 100, 0); else set_m0(0, 0, 0, 0, 0);
      @(negedge clk);
      model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL single_read c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (c == 1) begin
        n_tests++;
        if (m0_rdata !== 32'd5 || m0_rvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL single_read_data: rvalid=%b rdata=%h required 1/5", m0_rvalid, m0_rdata);
        end
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_alternating();
    int g0_seen = 0, g1_seen = 0;
    do_reset();
    set_m0(1, 0, 0, 101, 0);
    set_m1(1, 0, 0, 102, 0);
    for (int c = 0; c < 9; c++) begin
      if (c == 8) begin set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0); end
      @(negedge clk);
      model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL alternating c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (mdl_pend_rv[0] || mdl_pend_rv[1]) begin
        n_tests++;
        if (m0_rdata !== mdl_pend_data) begin
          n_fail++;
          $display("FAIL alternating_data c%0d: got %h required %h", c, m0_rdata, mdl_pend_data);
        end
      end
      if (c < 8) begin
        n_tests++;
        if ((c % 2 == 0 && m0_gnt !== 1'b1) || (c % 2 == 1 && m1_gnt !== 1'b1)) begin
          n_fail++;
          $display("FAIL alternating_order c%0d: gnt=%b%b required port %0d", c, m0_gnt, m1_gnt, c % 2);
        end
      end
      g0_seen += m0_gnt; g1_seen += m1_gnt;
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_write_then_read();
    for (int c = 0; c < 3; c++) begin
      set_m0(c == 1, 0, 0, 103, 0);
      set_m1(c == 0, 1, 0, 103, 32'hFFFF_FFFF);
      @(negedge clk);
      model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL write_read c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (c == 2) begin
        n_tests++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hFFFF_FFFF) begin
          n_fail++;
          $display("FAIL write_read_data: rvalid=%b rdata=%h required 1/ffffffff", m0_rvalid, m0_rdata);
        end
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_lock();
    int run0 = 0;
    bit handed = 0;
    do_reset();
    set_m0(1, 0, 1, 200, 0);
    set_m1(1, 0, 0, 201, 0);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL lock c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (!handed && m0_gnt) run0++;
      if (m1_gnt) handed = 1;
      @(posedge clk); model_commit(); #1;
    end
    n_tests++;
    if (run0 !== MAXLOCK + 1 || !handed) begin
      n_fail++;
      $display("FAIL lock_run: m0 grants before hand-over %0d required %0d", run0, MAXLOCK + 1);
    end
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    set_m0(1, 0, 0, 100, 0);
    set_m1(0, 0, 0, 0, 0);
    @(negedge clk); model_eval();
    @(posedge clk); model_commit(); #1;
    rst = 1'b0;
    set_m0(0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) rst = 1'b1;
      if (c == 3) begin set_m0(1, 0, 0, 101, 0); set_m1(1, 0, 0, 102, 0); end
      @(negedge clk);
      model_eval();
      n_tests++;
      if (obs_vec !== exp_vec || m0_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (c == 3) begin
        n_tests++;
        if (m0_gnt !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_mid_tie: m0_gnt=%b required 1", m0_gnt);
        end
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_idle();
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    for (int c = 0; c < 7; c++) begin
      if (c == 6) begin set_m0(1, 0, 0, 101, 0); set_m1(1, 0, 0, 102, 0); end
      @(negedge clk);
      model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL idle c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      @(posedge clk); model_commit(); #1;
    end
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_m0($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
             $urandom_range(96, 111), $urandom);
      set_m1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
             $urandom_range(96, 111), $urandom);
      @(negedge clk);
      model_eval();
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random c%0d: got %h required %h", c, obs_vec, exp_vec);
      end
      if (mdl_pend_rv[0] || mdl_pend_rv[1]) begin
        n_tests++;
        if (m0_rdata !== mdl_pend_data || m1_rdata !== mdl_pend_data) begin
          n_fail++;
          $display("FAIL random_data c%0d: got %h/%h required %h", c, m0_rdata, m1_rdata, mdl_pend_data);
        end
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    set_m0(0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0);
    for (int i = 0; i < 128; i++) preload(i, 32'hA000_0000 + i);
    preload(100, 32'd5);
    preload(101, 32'd8);
    preload(102, 32'd16);
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_alternating();
    test_write_then_read();
    test_lock();
    test_reset_mid();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: SIZE, 14, RAM address width.
REQ-002 Parameter: MAXLOCK, 8, max consecutive locked grants before forced hand-over.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 m0_req / m1_req  input  1  access request, held until granted.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 m0_lock / m1_lock  input  1  request to keep ownership on the next cycle.
REQ-008 m0_addr / m1_addr  input  SIZE  word address.
REQ-009 m0_wdata / m1_wdata  input  32  write data.
REQ-010 m0_gnt / m1_gnt  output  1  combinational grant; access executes this cycle.
REQ-011 m0_rvalid / m1_rvalid  output  1  read data valid, one cycle after granted read.
REQ-012 m0_rdata / m1_rdata  output  32  both driven from ram_dout; meaningful only with rvalid.
REQ-013 ram_we  output  1  RAM write enable.
REQ-014 ram_addr  output  SIZE  RAM address.
REQ-015 ram_din  output  32  RAM write data.
REQ-016 ram_dout  input  32  RAM read data, registered in RAM (1-cycle latency).

Function
REQ-017 At most one of m0_gnt/m1_gnt SHALL be high in any cycle; no request -> both low.
REQ-018 Single requester SHALL be granted in the same cycle (zero-wait).
REQ-019 Both requesting, no active lock: grant SHALL go to the port not granted most recently (round-robin via 1-bit last register).
REQ-020 Active lock: last owner requesting with its lock bit set on its previous grant SHALL win the next cycle over the other port.
REQ-021 Lock asserted by a non-owner, or with req low, SHALL be ignored.
REQ-022 A 4-bit lock counter SHALL count consecutive locked grants; when count reaches MAXLOCK and the other port requests, grant SHALL pass to the other port and the counter SHALL clear.
REQ-023 Counter SHALL clear on any ownership change or on any cycle with no grant.
REQ-024 Granted port's we/addr/wdata SHALL drive ram_we/ram_addr/ram_din combinationally; no grant -> ram_we=0, ram_addr=0, ram_din=0.
REQ-025 Granted read in cycle N SHALL raise that port's rvalid in cycle N+1 for exactly one cycle; writes SHALL produce no rvalid.
REQ-026 Back-to-back reads by alternating ports SHALL each receive their own rvalid with no lost or swapped data.
REQ-027 A read and a write are never simultaneous (one RAM port); write-then-read same address on consecutive cycles SHALL return the new data (RAM write-first).
REQ-028 The last register SHALL update only on cycles with a grant.

Reset
REQ-029 rst low SHALL immediately force: last=1 (port 0 wins first tie), lock counter=0, m0_rvalid=m1_rvalid=0.
REQ-030 Reset asserted mid-operation SHALL discard any pending rvalid; no rvalid after release until a new granted read.
REQ-031 While rst low, gnt outputs SHALL be 0 and ram_we SHALL be 0.

Verification
REQ-032 Preload mem[100]=5; m0 read addr 100 alone -> m0_gnt same cycle, m0_rvalid next cycle, m0_rdata=5, m1_rvalid=0.
REQ-033 Both read continuously (m0 addr 101=8, m1 addr 102=16), no lock, after reset -> grants m0,m1,m0,m1...; rvalid alternates, data 8/16 correctly steered.
REQ-034 m1 writes 0xFFFFFFFF to 103, then m0 reads 103 next cycle -> m0_rdata=0xFFFFFFFF.
REQ-035 m0 holds req+lock, m1 requests continuously -> m0 granted 1 (arbitration win) + 8 locked cycles, then m1 granted; counter cleared.
REQ-036 Reset pulse in cycle after m0 granted read -> m0_rvalid stays 0; first post-reset tie goes to m0.
REQ-037 Idle (no req) 5 cycles -> ram_we=0, ram_addr=0, no rvalid, last unchanged.
